apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, sets the number of ACCESS cycles with PREADY low before abort (used only with APB_MASTER_TIMEOUT_EN).
REQ-002 PCLK  input  1  single clock; all state changes on its rising edge.
REQ-003 PRESET  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  requester offers a transfer.
REQ-005 req_ready  output  1  master accepts a request this cycle.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  64  transfer address.
REQ-008 req_wdata  input  64  write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  64  read data; 0 for writes and aborts.
REQ-011 rsp_err  output  1  completion carried an error.
REQ-012 cs  output  1  bus chip-select, high in SETUP and ACCESS.
REQ-013 PSEL1  output  1  slave-select bit 0.
REQ-014 PSEL2  output  1  slave-select bit 1.
REQ-015 PENABLE  output  1  APB access phase.
REQ-016 PWRITE  output  1  APB direction.
REQ-017 PADDR  output  64  APB address.
REQ-018 PWDATA  output  64  APB write data.
REQ-019 PRDATA  input  64  OR-combined slave read data.
REQ-020 PREADY  input  1  OR-combined slave ready.
REQ-021 slverr  input  1  OR-combined slave error.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, SETUP, ACCESS.
REQ-023 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid and req_ready are both 1 at a PCLK edge.
REQ-024 On handshake, req_write/req_addr/req_wdata SHALL be latched; the state goes to SETUP at the same edge.
REQ-025 SETUP (exactly one cycle): cs=1, PENABLE=0, {PSEL2,PSEL1}=latched addr[63:62], PADDR/PWRITE/PWDATA = latched values; next state is ACCESS.
REQ-026 ACCESS: cs, PSEL1/2, PADDR, PWRITE, PWDATA SHALL hold their SETUP values; PENABLE=1.
REQ-027 ACCESS with PREADY=0 at an edge SHALL remain in ACCESS (wait state), outputs unchanged.
REQ-028 ACCESS with PREADY=1 at an edge SHALL go to IDLE and, in the following cycle, drive rsp_valid=1, rsp_err=slverr, rsp_rdata=PRDATA for reads or 0 for writes.
REQ-029 rsp_valid SHALL be high for exactly one cycle per transfer; rsp_rdata/rsp_err SHALL hold until the next completion.
REQ-030 In IDLE, cs, PSEL1, PSEL2 and PENABLE SHALL be 0; PADDR/PWDATA/PWRITE hold their last values.
REQ-031 Minimum latency: handshake at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid in cycle N+3; req_ready SHALL return to 1 in the same cycle as rsp_valid.
REQ-032 req_valid asserted outside IDLE SHALL be ignored; no request is queued.
REQ-033 slverr and PRDATA SHALL be sampled only in ACCESS cycles with PREADY=1.

Reset
REQ-034 PRESET=1 at an edge SHALL force IDLE and zero every output except req_ready (1 after reset), regardless of the current state; an in-flight transfer is dropped without rsp_valid.
REQ-035 Reset state: rsp_valid=0, rsp_err=0, rsp_rdata=0, cs=0, PSEL1=0, PSEL2=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, timeout counter=0.

Configuration
REQ-036 With APB_MASTER_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with PREADY=0; when it reaches TIMEOUT_CYCLES, the master SHALL go to IDLE and give rsp_valid=1, rsp_err=1, rsp_rdata=0 in the next cycle. The counter clears on entry to SETUP.
REQ-037 Without APB_MASTER_TIMEOUT_EN, no counter exists and ACCESS SHALL wait indefinitely for PREADY.

Verification
REQ-038 Write: addr=0x4000_0000_0000_0010, wdata=0xDEAD_BEEF, PREADY tied 1 -> PSEL2:1=01, PENABLE high for 1 cycle, rsp_valid in cycle N+3, rsp_err=0, rsp_rdata=0.
REQ-039 Read: addr=0xC000_0000_0000_0008, PREADY low for 3 ACCESS cycles, PRDATA=0x1234 -> PSEL2:1=11 held for 5 cycles, rsp_rdata=0x1234.
REQ-040 Error: slverr=1 with PREADY=1 -> rsp_err=1; the next transfer with slverr=0 gives rsp_err=0.
REQ-041 Back-to-back: req_valid held high for 2 requests -> second SETUP in cycle N+4; no overlap of cs between transfers.
REQ-042 PRESET pulsed in ACCESS -> next cycle all bus outputs 0, req_ready=1, no rsp_valid.
REQ-043 With APB_MASTER_TIMEOUT_EN and PREADY stuck 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/apb_master.sv
// APB master: one request/response port in, single APB transfer at a time out.
// Optional ACCESS-phase timeout is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        cs,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [63:0] PADDR,
    output logic [63:0] PWDATA,
    input  logic [63:0] PRDATA,
    input  logic        PREADY,
    input  logic        slverr
);

    // Handshake: a request transfers at a PCLK edge where req_valid && req_ready.
    // req_ready is high only in IDLE, so nothing is ever queued behind a transfer.

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("apb_master: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    logic [1:0]  state;
    logic        write_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state   <= SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                        tcnt    <= '0;
`endif
                    end
                end
                SETUP: state <= ACCESS;
                ACCESS: begin
                    // PRDATA and slverr are only meaningful on the completing cycle.
                    if (PREADY) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= slverr;
                        rsp_rdata <= write_q ? 64'd0 : PRDATA;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 64'd0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign cs        = (state != IDLE);
    assign PENABLE   = (state == ACCESS);
    assign PSEL1     = cs & addr_q[62];
    assign PSEL2     = cs & addr_q[63];
    assign PWRITE    = write_q;
    assign PADDR     = addr_q;
    assign PWDATA    = wdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: driver tasks issue transfers and push expected
// responses; a monitor pops and compares every rsp_valid pulse.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        cs;
    logic        PSEL1;
    logic        PSEL2;
    logic        PENABLE;
    logic        PWRITE;
    logic [63:0] PADDR;
    logic [63:0] PWDATA;
    logic [63:0] PRDATA;
    logic        PREADY;
    logic        slverr;

    int tests_run = 0;
    int fail_count = 0;
    logic [64:0] exp_q[$];

    apb_master #(.TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cs(cs), .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .slverr(slverr)
    );

    // clock / time limit
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL time_limit: simulation did not finish, act=running exp=done");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge PCLK);
            if (rsp_valid === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fail_count++;
                    $display("FAIL rsp_unexpected: act err=%0b rdata=0x%0h exp=no response", rsp_err, rsp_rdata);
                end else begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    if ({rsp_err, rsp_rdata} !== e) begin
                        fail_count++;
                        $display("FAIL rsp_data: act err=%0b rdata=0x%0h exp err=%0b rdata=0x%0h",
                                 rsp_err, rsp_rdata, e[64], e[63:0]);
                    end
                end
            end
        end
    end

    task automatic check_bus_active(input string tag, input logic [63:0] addr, input logic w,
                                    input logic [63:0] wd, input logic en);
        check({tag, "_cs"}, {63'd0, cs}, 64'd1);
        check({tag, "_penable"}, {63'd0, PENABLE}, {63'd0, en});
        check({tag, "_psel"}, {62'd0, PSEL2, PSEL1}, {62'd0, addr[63:62]});
        check({tag, "_paddr"}, PADDR, addr);
        check({tag, "_pwrite"}, {63'd0, PWRITE}, {63'd0, w});
        check({tag, "_pwdata"}, PWDATA, wd);
        check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd0);
    endtask

    // One full transfer: `waits` ACCESS cycles with PREADY low, then one with PREADY high.
    task automatic xfer(input string tag, input logic w, input logic [63:0] addr, input logic [63:0] wd,
                        input int waits, input logic [63:0] rd, input logic err);
        @(negedge PCLK);
        check({tag, "_idle_ready"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wd;
        exp_q.push_back({err, (w ? 64'd0 : rd)});
        @(negedge PCLK);
        check_bus_active({tag, "_setup"}, addr, w, wd, 1'b0);
        req_valid = 1'b1; req_write = ~w; req_addr = 64'hFFFF_0000_0000_0000;
        for (int i = 0; i <= waits; i++) begin
            @(negedge PCLK);
            req_valid = 1'b0;
            check_bus_active({tag, "_access"}, addr, w, wd, 1'b1);
            check({tag, "_no_early_rsp"}, {63'd0, rsp_valid}, 64'd0);
            PREADY = (i == waits);
            PRDATA = (i == waits) ? rd : 64'hBAD0_BAD0_BAD0_BAD0;
            slverr = (i == waits) ? err : 1'b1;
        end
        @(negedge PCLK);
        check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        check({tag, "_done_cs"}, {60'd0, cs, PSEL2, PSEL1, PENABLE}, 64'd0);
        check({tag, "_done_ready"}, {63'd0, req_ready}, 64'd1);
        check({tag, "_paddr_hold"}, PADDR, addr);
        PREADY = 1'b0; slverr = 1'b0; PRDATA = 64'hBAD1_BAD1_BAD1_BAD1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
        check({tag, "_flags"}, {58'd0, rsp_valid, rsp_err, cs, PSEL1, PSEL2, PENABLE}, 64'd0);
        check({tag, "_pwrite"}, {63'd0, PWRITE}, 64'd0);
        check({tag, "_paddr"}, PADDR, 64'd0);
        check({tag, "_pwdata"}, PWDATA, 64'd0);
        check({tag, "_rdata"}, rsp_rdata, 64'd0);
    endtask

    initial begin
        PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; slverr = 1'b0;
        repeat (2) @(negedge PCLK);
        check_reset_outputs("reset");
        PRESET = 1'b0;

        // write, zero wait states
        xfer("wr", 1'b1, 64'h4000_0000_0000_0010, 64'h0000_0000_DEAD_BEEF, 0, 64'h0, 1'b0);
        // read, three wait states
        xfer("rd", 1'b0, 64'hC000_0000_0000_0008, 64'h0, 3, 64'h1234, 1'b0);
        @(negedge PCLK);
        check("rsp_hold_rdata", rsp_rdata, 64'h1234);
        check("rsp_single_pulse", {63'd0, rsp_valid}, 64'd0);

        // slave error then clean transfer
        xfer("err", 1'b0, 64'h8000_0000_0000_0100, 64'h0, 1, 64'h77, 1'b1);
        xfer("ok", 1'b1, 64'h0000_0000_0000_0200, 64'h55, 0, 64'h0, 1'b0);

        // back-to-back with req_valid held high
        @(negedge PCLK);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h4000_0000_0000_0A00; req_wdata = 64'hA1;
        exp_q.push_back({1'b0, 64'h0});
        @(negedge PCLK);
        check("b2b_setup_a", PADDR, 64'h4000_0000_0000_0A00);
        req_write = 1'b0; req_addr = 64'h8000_0000_0000_0B00; req_wdata = 64'hB2;
        exp_q.push_back({1'b0, 64'h5A5A});
        PREADY = 1'b1; PRDATA = 64'h5A5A;
        @(negedge PCLK);
        check("b2b_access_a_paddr", PADDR, 64'h4000_0000_0000_0A00);
        check("b2b_access_a_pen", {63'd0, PENABLE}, 64'd1);
        @(negedge PCLK);
        check("b2b_gap_cs", {63'd0, cs}, 64'd0);
        check("b2b_gap_rsp", {63'd0, rsp_valid}, 64'd1);
        @(negedge PCLK);
        req_valid = 1'b0;
        check_bus_active("b2b_setup_b", 64'h8000_0000_0000_0B00, 1'b0, 64'hB2, 1'b0);
        @(negedge PCLK);
        check("b2b_access_b_pen", {63'd0, PENABLE}, 64'd1);
        @(negedge PCLK);
        check("b2b_done_b", {62'd0, rsp_valid, cs}, 64'd2);
        PREADY = 1'b0;

        // reset during ACCESS drops the transfer
        @(negedge PCLK);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'hC000_0000_0000_0C00; req_wdata = 64'hC3;
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        check("rst_in_access_pen", {63'd0, PENABLE}, 64'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        check_reset_outputs("rst_access");
        repeat (2) @(negedge PCLK);
        check("rst_no_rsp", {63'd0, rsp_valid}, 64'd0);

`ifdef APB_MASTER_TIMEOUT_EN
        // PREADY stuck low: abort after 16 ACCESS cycles
        @(negedge PCLK);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h4000_0000_0000_0D00; req_wdata = '0;
        exp_q.push_back({1'b1, 64'h0});
        @(negedge PCLK);
        req_valid = 1'b0;
        PRDATA = 64'hDDDD;
        for (int i = 0; i < 16; i++) begin
            @(negedge PCLK);
            check("to_access_pen", {63'd0, PENABLE}, 64'd1);
            check("to_no_early_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        @(negedge PCLK);
        check("to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("to_cs_low", {63'd0, cs}, 64'd0);
`else
        // no timeout: a long wait still completes normally
        xfer("long", 1'b0, 64'h4000_0000_0000_0D00, 64'h0, 20, 64'hFEED, 1'b0);
`endif

        repeat (3) @(negedge PCLK);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
